mem_stage_ls: RTL and testbench

Parametrised successor to the pipeline's memory stage. It holds the EX/MEM pipeline register and resolves branches and jumps toward IF. It performs byte, half and word (and dword when DATA_W=64) loads and stores through a valid/ready request port and a variable-latency response port. It raises stall_m to the hazard unit while an access is pending.

---
 rtl/mem_stage_ls_if.sv | 39 +++
 rtl/mem_stage_ls.sv | 239 +++++++++++++++++++++++
 tb/tb_mem_stage_ls.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_ls_if.sv
// -----------------------------------------------------------------------------
// mem_stage_ls_if
// Memory-side bus of the load/store stage: a valid/ready request channel and a
// variable-latency read response channel.
//   master : the memory stage (drives requests, receives responses)
//   slave  : the memory / bus model
// Signals:
//   mem_req_valid / mem_req_ready   request handshake
//   mem_req_we                      request is a write
//   mem_req_addr                    aligned address (ADDR_W)
//   mem_req_be                      byte enables (DATA_W/8)
//   mem_req_wdata                   lane-replicated store data (DATA_W)
//   mem_resp_valid / mem_resp_rdata read response
// -----------------------------------------------------------------------------
interface mem_stage_ls_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32
);
   localparam int BE_W = DATA_W / 8;

   logic              mem_req_valid;
   logic              mem_req_ready;
   logic              mem_req_we;
   logic [ADDR_W-1:0] mem_req_addr;
   logic [BE_W-1:0]   mem_req_be;
   logic [DATA_W-1:0] mem_req_wdata;
   logic              mem_resp_valid;
   logic [DATA_W-1:0] mem_resp_rdata;

   modport master (
      output mem_req_valid, mem_req_we, mem_req_addr, mem_req_be, mem_req_wdata,
      input  mem_req_ready, mem_resp_valid, mem_resp_rdata
   );

   modport slave (
      input  mem_req_valid, mem_req_we, mem_req_addr, mem_req_be, mem_req_wdata,
      output mem_req_ready, mem_resp_valid, mem_resp_rdata
   );
endinterface

// File: rtl/mem_stage_ls.sv
// -----------------------------------------------------------------------------
// mem_stage_ls
// Pipeline memory stage: EX/MEM register, branch/jump redirect toward IF,
// byte/half/word(/dword when DATA_W=64) loads and stores over mem_stage_ls_if.
// stall_m is high while an access is in flight.
//
// Optional feature macro: MEM_STAGE_MISALIGN_TRAP_EN
//   defined   : misaligned accesses are not issued; misalign_m pulses and the
//               instruction retires with m_reg_write forced low.
//   undefined : misaligned addresses are aligned down and issued normally.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   ex_*                        instruction/controls from EX
//   if_pc_src, if_pc_branch_in  combinational redirect toward IF
//   mem                         request/response bus (master side)
//   misalign_m                  misaligned-access flag (feature only)
//   stall_m                     freeze IF/ID/EX
//   m_*                         registered results toward WB
// -----------------------------------------------------------------------------
module mem_stage_ls #(
   parameter int DATA_W     = 32,
   parameter int ADDR_W     = 32,
   parameter int REG_ADDR_W = 5,
   parameter int BE_W       = DATA_W / 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  ex_valid,
   input  logic                  ex_reg_write,
   input  logic                  ex_mem_to_reg,
   input  logic                  ex_mem_read,
   input  logic                  ex_mem_write,
   input  logic [1:0]            ex_size,
   input  logic                  ex_unsigned,
   input  logic [DATA_W-1:0]     ex_alu_out,
   input  logic [DATA_W-1:0]     ex_write_data,
   input  logic [REG_ADDR_W-1:0] ex_write_reg,
   input  logic                  ex_branch,
   input  logic                  ex_zero,
   input  logic [1:0]            ex_j_inst,
   input  logic [ADDR_W-1:0]     ex_pc_branch,
   input  logic [ADDR_W-1:0]     ex_jump_addr,
   output logic [1:0]            if_pc_src,
   output logic [ADDR_W-1:0]     if_pc_branch_in,
   mem_stage_ls_if.master        mem,
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
   output logic                  misalign_m,
`endif
   output logic                  stall_m,
   output logic                  m_valid,
   output logic                  m_reg_write,
   output logic                  m_mem_to_reg,
   output logic [DATA_W-1:0]     m_alu_out,
   output logic [DATA_W-1:0]     m_read_data,
   output logic [REG_ADDR_W-1:0] m_write_reg
);
   localparam int OFFW = $clog2(BE_W);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

   // A dword request on a 32-bit datapath degrades to a word access.
   function automatic logic [1:0] eff_size(input logic [1:0] s);
      if (DATA_W == 32 && s == 2'b11) return 2'b10;
      return s;
   endfunction

   state_t                r_state, w_state_next;
   logic                  r_valid, r_reg_write, r_mem_to_reg, r_mem_write, r_unsigned;
   logic [1:0]            r_size;
   logic [DATA_W-1:0]     r_alu_out, r_write_data, r_read_data;
   logic [REG_ADDR_W-1:0] r_write_reg;

   logic                  w_gate, w_ex_memop, w_ex_misalign;
   logic [1:0]            w_size;
   logic [OFFW-1:0]       w_off;
   logic [BE_W-1:0]       w_be;
   logic [DATA_W-1:0]     w_wdata, w_lane_b, w_lane_h, w_lane_w, w_shifted, w_load_data;

   assign stall_m    = (r_state != S_IDLE);
   assign w_ex_memop = ex_valid & (ex_mem_read | ex_mem_write);

   // ---------------- redirect toward IF ----------------
   assign w_gate = ex_valid & ex_branch & ~stall_m;

   always_comb begin
      if_pc_src       = 2'b00;
      if_pc_branch_in = '0;
      if (w_gate & (ex_zero | (ex_j_inst != 2'b00))) if_pc_src = 2'b01;
      if (w_gate) begin
         if (ex_zero)                  if_pc_branch_in = ex_pc_branch;
         else if (ex_j_inst == 2'b11)  if_pc_branch_in = ex_alu_out[ADDR_W-1:0];
         else if (ex_j_inst != 2'b00)  if_pc_branch_in = ex_jump_addr;
      end
   end

   // ---------------- misalignment on the incoming instruction ----------------
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
   logic            r_misalign;
   logic [OFFW-1:0] w_ex_off;
   assign w_ex_off = ex_alu_out[OFFW-1:0];

   always_comb begin
      w_ex_misalign = 1'b0;
      case (eff_size(ex_size))
         2'b00:   w_ex_misalign = 1'b0;
         2'b01:   w_ex_misalign = w_ex_off[0];
         2'b10:   w_ex_misalign = |w_ex_off[1:0];
         default: w_ex_misalign = |w_ex_off;
      endcase
      w_ex_misalign = w_ex_misalign & w_ex_memop;
   end

   assign misalign_m  = r_misalign;
   assign m_reg_write = r_reg_write & ~r_misalign;
`else
   assign w_ex_misalign = 1'b0;
   assign m_reg_write   = r_reg_write;
`endif

   // ---------------- FSM ----------------
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:  if (w_ex_memop & ~w_ex_misalign) w_state_next = S_REQ;
         S_REQ:   if (mem.mem_req_ready) w_state_next = r_mem_write ? S_IDLE : S_WAIT;
         S_WAIT:  if (mem.mem_resp_valid) w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   // ---------------- request formation ----------------
   assign w_size = eff_size(r_size);

   // Lane offset with the bits below the access size cleared, so a
   // misaligned address is aligned down to its natural boundary.
   always_comb begin
      w_off = r_alu_out[OFFW-1:0];
      case (w_size)
         2'b00:   w_off = r_alu_out[OFFW-1:0];
         2'b01:   w_off = r_alu_out[OFFW-1:0] & ~OFFW'(1);
         2'b10:   w_off = r_alu_out[OFFW-1:0] & ~OFFW'(3);
         default: w_off = '0;
      endcase
   end

   always_comb begin
      w_be = '1;
      case (w_size)
         2'b00:   w_be = BE_W'(1)  << w_off;
         2'b01:   w_be = BE_W'(3)  << w_off;
         2'b10:   w_be = BE_W'(15) << w_off;
         default: w_be = '1;
      endcase
   end

   // Replicate the right-aligned store data into every lane of its size.
   for (genvar gi = 0; gi < BE_W; gi++) begin : g_lane
      assign w_lane_b[gi*8 +: 8] = r_write_data[7:0];
      assign w_lane_h[gi*8 +: 8] = r_write_data[(gi%2)*8 +: 8];
      assign w_lane_w[gi*8 +: 8] = r_write_data[(gi%4)*8 +: 8];
   end

   always_comb begin
      w_wdata = r_write_data;
      case (w_size)
         2'b00:   w_wdata = w_lane_b;
         2'b01:   w_wdata = w_lane_h;
         2'b10:   w_wdata = w_lane_w;
         default: w_wdata = r_write_data;
      endcase
   end

   assign mem.mem_req_valid = (r_state == S_REQ);
   assign mem.mem_req_we    = r_mem_write;
   assign mem.mem_req_addr  = {r_alu_out[ADDR_W-1:OFFW], {OFFW{1'b0}}};
   assign mem.mem_req_be    = w_be;
   assign mem.mem_req_wdata = w_wdata;

   // ---------------- load extraction ----------------
   assign w_shifted = mem.mem_resp_rdata >> {w_off, 3'b000};

   always_comb begin
      w_load_data = w_shifted;
      case (w_size)
         2'b00:   w_load_data = r_unsigned ? DATA_W'(w_shifted[7:0])
                                           : DATA_W'($signed(w_shifted[7:0]));
         2'b01:   w_load_data = r_unsigned ? DATA_W'(w_shifted[15:0])
                                           : DATA_W'($signed(w_shifted[15:0]));
         2'b10:   w_load_data = r_unsigned ? DATA_W'(w_shifted[31:0])
                                           : DATA_W'($signed(w_shifted[31:0]));
         default: w_load_data = w_shifted;
      endcase
   end

   // ---------------- registers ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_valid      <= 1'b0;
         r_reg_write  <= 1'b0;
         r_mem_to_reg <= 1'b0;
         r_mem_write  <= 1'b0;
         r_unsigned   <= 1'b0;
         r_size       <= 2'b00;
         r_alu_out    <= '0;
         r_write_data <= '0;
         r_write_reg  <= '0;
         r_read_data  <= '0;
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
         r_misalign   <= 1'b0;
`endif
      end else begin
         r_state <= w_state_next;
         if (!stall_m) begin
            r_valid      <= ex_valid;
            r_reg_write  <= ex_reg_write;
            r_mem_to_reg <= ex_mem_to_reg;
            r_mem_write  <= ex_mem_write;
            r_unsigned   <= ex_unsigned;
            r_size       <= ex_size;
            r_alu_out    <= ex_alu_out;
            r_write_data <= ex_write_data;
            r_write_reg  <= ex_write_reg;
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
            r_misalign   <= w_ex_misalign;
`endif
         end
         // Only a response in WAIT is accepted; one arriving in REQ or IDLE is dropped.
         if (r_state == S_WAIT && mem.mem_resp_valid) r_read_data <= w_load_data;
      end
   end

   assign m_valid      = r_valid & (r_state == S_IDLE);
   assign m_mem_to_reg = r_mem_to_reg;
   assign m_alu_out    = r_alu_out;
   assign m_read_data  = r_read_data;
   assign m_write_reg  = r_write_reg;
endmodule

// File: tb/tb_mem_stage_ls.sv
module tb_mem_stage_ls;
   localparam int DW = 32;
   localparam int AW = 32;
   localparam int RW = 5;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          ex_valid, ex_reg_write, ex_mem_to_reg, ex_mem_read, ex_mem_write;
   logic [1:0]    ex_size;
   logic          ex_unsigned;
   logic [DW-1:0] ex_alu_out, ex_write_data;
   logic [RW-1:0] ex_write_reg;
   logic          ex_branch, ex_zero;
   logic [1:0]    ex_j_inst;
   logic [AW-1:0] ex_pc_branch, ex_jump_addr;
   logic [1:0]    if_pc_src;
   logic [AW-1:0] if_pc_branch_in;
   logic          stall_m, m_valid, m_reg_write, m_mem_to_reg;
   logic [DW-1:0] m_alu_out, m_read_data;
   logic [RW-1:0] m_write_reg;
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
   logic          misalign_m;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   mem_stage_ls_if #(.DATA_W(DW), .ADDR_W(AW)) mem_if ();

   mem_stage_ls #(.DATA_W(DW), .ADDR_W(AW), .REG_ADDR_W(RW)) dut (
      .clk(clk), .rst_n(rst_n),
      .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg),
      .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_size(ex_size),
      .ex_unsigned(ex_unsigned), .ex_alu_out(ex_alu_out), .ex_write_data(ex_write_data),
      .ex_write_reg(ex_write_reg), .ex_branch(ex_branch), .ex_zero(ex_zero),
      .ex_j_inst(ex_j_inst), .ex_pc_branch(ex_pc_branch), .ex_jump_addr(ex_jump_addr),
      .if_pc_src(if_pc_src), .if_pc_branch_in(if_pc_branch_in), .mem(mem_if),
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
      .misalign_m(misalign_m),
`endif
      .stall_m(stall_m), .m_valid(m_valid), .m_reg_write(m_reg_write),
      .m_mem_to_reg(m_mem_to_reg), .m_alu_out(m_alu_out), .m_read_data(m_read_data),
      .m_write_reg(m_write_reg)
   );

   typedef struct {
      logic v, br, z; logic [1:0] j;
      logic [31:0] pcb, jaddr, alu;
      logic [1:0] exp_src; logic [31:0] exp_tgt;
   } rd_vec_t;

   typedef struct {
      logic [1:0] size; logic [31:0] addr, wdata, exp_addr;
      logic [3:0] exp_be; logic [31:0] exp_wdata; int waits;
   } st_vec_t;

   typedef struct {
      logic [1:0] size; logic uns; logic [31:0] addr, rdata, exp_addr;
      logic [3:0] exp_be; logic [31:0] exp_data; int lat;
   } ld_vec_t;

   rd_vec_t rd_tab [8];
   st_vec_t st_tab [6];
   ld_vec_t ld_tab [6];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic clear_ex();
      ex_valid = 0; ex_reg_write = 0; ex_mem_to_reg = 0; ex_mem_read = 0; ex_mem_write = 0;
      ex_size = 2'b00; ex_unsigned = 0; ex_alu_out = '0; ex_write_data = '0;
      ex_write_reg = '0; ex_branch = 0; ex_zero = 0; ex_j_inst = 2'b00;
      ex_pc_branch = '0; ex_jump_addr = '0;
   endtask

   task automatic do_store(input st_vec_t v, input int idx);
      int stalls;
      @(negedge clk);
      clear_ex();
      ex_valid = 1; ex_mem_write = 1; ex_size = v.size; ex_alu_out = v.addr;
      ex_write_data = v.wdata; ex_write_reg = 5'd9;
      mem_if.mem_req_ready = 0;
      stalls = 0;
      for (int i = 0; i <= v.waits; i++) begin
         @(negedge clk);
         clear_ex();
         mem_if.mem_req_ready = (i == v.waits);
         #1;
         if (stall_m) stalls++;
         chk($sformatf("st%0d req_valid", idx), mem_if.mem_req_valid, 1);
         chk($sformatf("st%0d we", idx), mem_if.mem_req_we, 1);
         chk($sformatf("st%0d addr", idx), mem_if.mem_req_addr, v.exp_addr);
         chk($sformatf("st%0d be", idx), mem_if.mem_req_be, v.exp_be);
         chk($sformatf("st%0d wdata", idx), mem_if.mem_req_wdata, v.exp_wdata);
         if (i == 0) begin
            // a taken branch seen while stalled must not redirect
            ex_valid = 1; ex_branch = 1; ex_zero = 1; ex_pc_branch = 32'h40;
            #1;
            chk($sformatf("st%0d redirect_while_stalled", idx), if_pc_src, 2'b00);
            clear_ex();
         end
      end
      @(negedge clk);
      mem_if.mem_req_ready = 0;
      #1;
      chk($sformatf("st%0d stall_cycles", idx), stalls, v.waits + 1);
      chk($sformatf("st%0d stall_done", idx), stall_m, 0);
      chk($sformatf("st%0d m_valid", idx), m_valid, 1);
      chk($sformatf("st%0d m_reg_write", idx), m_reg_write, 0);
      $display("store %0d: addr=%h be=%b wdata=%h stalls=%0d", idx, v.addr, v.exp_be, v.exp_wdata, stalls);
   endtask

   task automatic do_load(input ld_vec_t v, input int idx);
      int stalls;
      @(negedge clk);
      clear_ex();
      ex_valid = 1; ex_mem_read = 1; ex_reg_write = 1; ex_mem_to_reg = 1;
      ex_size = v.size; ex_unsigned = v.uns; ex_alu_out = v.addr; ex_write_reg = 5'd7;
      @(negedge clk);
      clear_ex();
      #1;
      chk($sformatf("ld%0d req_valid", idx), mem_if.mem_req_valid, 1);
      chk($sformatf("ld%0d we", idx), mem_if.mem_req_we, 0);
      chk($sformatf("ld%0d addr", idx), mem_if.mem_req_addr, v.exp_addr);
      chk($sformatf("ld%0d be", idx), mem_if.mem_req_be, v.exp_be);
      // response in the handshake cycle is not legal and must be dropped
      mem_if.mem_req_ready = 1; mem_if.mem_resp_valid = 1; mem_if.mem_resp_rdata = ~v.rdata;
      @(negedge clk);
      mem_if.mem_req_ready = 0; mem_if.mem_resp_valid = 0;
      #1;
      chk($sformatf("ld%0d req_dropped", idx), mem_if.mem_req_valid, 0);
      stalls = 0;
      for (int i = 0; i < v.lat; i++) begin
         if (i == v.lat - 1) begin
            mem_if.mem_resp_valid = 1; mem_if.mem_resp_rdata = v.rdata;
         end
         #1;
         if (stall_m) stalls++;
         @(negedge clk);
      end
      mem_if.mem_resp_valid = 0; mem_if.mem_resp_rdata = '0;
      #1;
      chk($sformatf("ld%0d stall_cycles", idx), stalls, v.lat);
      chk($sformatf("ld%0d stall_done", idx), stall_m, 0);
      chk($sformatf("ld%0d m_valid", idx), m_valid, 1);
      chk($sformatf("ld%0d m_read_data", idx), m_read_data, v.exp_data);
      chk($sformatf("ld%0d m_mem_to_reg", idx), m_mem_to_reg, 1);
      chk($sformatf("ld%0d m_write_reg", idx), m_write_reg, 7);
      $display("load %0d: addr=%h rdata=%h data=%h stalls=%0d", idx, v.addr, v.rdata, m_read_data, stalls);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      //                v  br z  j      pc_branch  jump_addr  alu_out     src    target
      rd_tab[0] = '{1, 1, 1, 2'b00, 32'h40,   32'h0,     32'h0,     2'b01, 32'h40};
      rd_tab[1] = '{1, 1, 0, 2'b11, 32'h44,   32'h0,     32'h1000,  2'b01, 32'h1000};
      rd_tab[2] = '{1, 1, 0, 2'b01, 32'h44,   32'h2000,  32'h0,     2'b01, 32'h2000};
      rd_tab[3] = '{1, 1, 0, 2'b10, 32'h44,   32'h3000,  32'h0,     2'b01, 32'h3000};
      rd_tab[4] = '{1, 1, 0, 2'b00, 32'h44,   32'h3000,  32'h10,    2'b00, 32'h0};
      rd_tab[5] = '{0, 1, 1, 2'b00, 32'h40,   32'h0,     32'h0,     2'b00, 32'h0};
      rd_tab[6] = '{1, 0, 1, 2'b11, 32'h40,   32'h0,     32'h1000,  2'b00, 32'h0};
      rd_tab[7] = '{1, 1, 1, 2'b11, 32'h80,   32'h0,     32'h1000,  2'b01, 32'h80};
      //                size   addr      wdata         exp_addr   be       exp_wdata   waits
      st_tab[0] = '{2'b00, 32'h1003, 32'h000000AB, 32'h1000, 4'b1000, 32'hABABABAB, 3};
      st_tab[1] = '{2'b00, 32'h1000, 32'h00000012, 32'h1000, 4'b0001, 32'h12121212, 0};
      st_tab[2] = '{2'b01, 32'h2002, 32'h0000BEEF, 32'h2000, 4'b1100, 32'hBEEFBEEF, 1};
      st_tab[3] = '{2'b01, 32'h2000, 32'h00001234, 32'h2000, 4'b0011, 32'h12341234, 0};
      st_tab[4] = '{2'b10, 32'h3004, 32'hCAFEF00D, 32'h3004, 4'b1111, 32'hCAFEF00D, 2};
      st_tab[5] = '{2'b11, 32'h3008, 32'h11223344, 32'h3008, 4'b1111, 32'h11223344, 0};
      //                size   uns addr      rdata         exp_addr   be       exp_data     lat
      ld_tab[0] = '{2'b01, 0, 32'h2002, 32'h80011234, 32'h2000, 4'b1100, 32'hFFFF8001, 5};
      ld_tab[1] = '{2'b01, 1, 32'h2002, 32'h80011234, 32'h2000, 4'b1100, 32'h00008001, 1};
      ld_tab[2] = '{2'b00, 0, 32'h2001, 32'h0000F000, 32'h2000, 4'b0010, 32'hFFFFFFF0, 2};
      ld_tab[3] = '{2'b00, 1, 32'h2003, 32'h7F000000, 32'h2000, 4'b1000, 32'h0000007F, 1};
      ld_tab[4] = '{2'b00, 0, 32'h2000, 32'h12345680, 32'h2000, 4'b0001, 32'hFFFFFF80, 3};
      ld_tab[5] = '{2'b10, 0, 32'h2004, 32'h89ABCDEF, 32'h2004, 4'b1111, 32'h89ABCDEF, 2};

      clear_ex();
      mem_if.mem_req_ready = 0; mem_if.mem_resp_valid = 0; mem_if.mem_resp_rdata = '0;

      // reset state
      #2;
      chk("reset req_valid", mem_if.mem_req_valid, 0);
      chk("reset stall_m", stall_m, 0);
      chk("reset m_valid", m_valid, 0);
      chk("reset m_reg_write", m_reg_write, 0);
      chk("reset m_alu_out", m_alu_out, 0);
      chk("reset m_read_data", m_read_data, 0);
      @(negedge clk);
      rst_n = 1;
      // stray response with nothing pending
      mem_if.mem_resp_valid = 1; mem_if.mem_resp_rdata = 32'hDEAD0000;
      @(negedge clk);
      mem_if.mem_resp_valid = 0;
      #1;
      chk("stray resp m_read_data", m_read_data, 0);
      chk("stray resp stall_m", stall_m, 0);
      $display("reset: done");

      // redirect table
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         clear_ex();
         ex_valid = rd_tab[i].v; ex_branch = rd_tab[i].br; ex_zero = rd_tab[i].z;
         ex_j_inst = rd_tab[i].j; ex_pc_branch = rd_tab[i].pcb;
         ex_jump_addr = rd_tab[i].jaddr; ex_alu_out = rd_tab[i].alu;
         #1;
         chk($sformatf("rd%0d if_pc_src", i), if_pc_src, rd_tab[i].exp_src);
         chk($sformatf("rd%0d target", i), if_pc_branch_in, rd_tab[i].exp_tgt);
         $display("redirect %0d: src=%b target=%h", i, if_pc_src, if_pc_branch_in);
      end

      // ALU op reaches WB the cycle after capture
      @(negedge clk);
      clear_ex();
      ex_valid = 1; ex_reg_write = 1; ex_alu_out = 32'h1234; ex_write_reg = 5'd4;
      @(negedge clk);
      clear_ex();
      #1;
      chk("alu m_valid", m_valid, 1);
      chk("alu m_alu_out", m_alu_out, 32'h1234);
      chk("alu stall_m", stall_m, 0);
      $display("alu: m_alu_out=%h", m_alu_out);

      for (int i = 0; i < 6; i++) begin
         do_store(st_tab[i], i);
         if (i == 0) begin
            // ADD right behind the store: retires one cycle later, no stall
            ex_valid = 1; ex_reg_write = 1; ex_alu_out = 32'h55; ex_write_reg = 5'd3;
            @(negedge clk);
            clear_ex();
            #1;
            chk("add m_valid", m_valid, 1);
            chk("add m_alu_out", m_alu_out, 32'h55);
            chk("add m_reg_write", m_reg_write, 1);
            chk("add m_write_reg", m_write_reg, 3);
            chk("add stall_m", stall_m, 0);
            $display("add after store: m_alu_out=%h", m_alu_out);
         end
      end

      for (int i = 0; i < 6; i++) do_load(ld_tab[i], i);

`ifdef MEM_STAGE_MISALIGN_TRAP_EN
      @(negedge clk);
      clear_ex();
      ex_valid = 1; ex_mem_read = 1; ex_reg_write = 1; ex_mem_to_reg = 1;
      ex_size = 2'b10; ex_alu_out = 32'h3002; ex_write_reg = 5'd6;
      @(negedge clk);
      clear_ex();
      #1;
      chk("misalign flag", misalign_m, 1);
      chk("misalign m_valid", m_valid, 1);
      chk("misalign m_reg_write", m_reg_write, 0);
      chk("misalign req_valid", mem_if.mem_req_valid, 0);
      chk("misalign stall_m", stall_m, 0);
      @(negedge clk);
      #1;
      chk("misalign one cycle", misalign_m, 0);
      $display("misaligned LW: trapped");
`else
      begin
         ld_vec_t mv;
         mv = '{2'b10, 0, 32'h3002, 32'hDEADBEEF, 32'h3000, 4'b1111, 32'hDEADBEEF, 1};
         do_load(mv, 6);
      end
`endif

      // reset while a load waits for its response
      @(negedge clk);
      clear_ex();
      ex_valid = 1; ex_mem_read = 1; ex_reg_write = 1; ex_mem_to_reg = 1;
      ex_size = 2'b10; ex_alu_out = 32'h4000; ex_write_reg = 5'd2;
      @(negedge clk);
      clear_ex();
      mem_if.mem_req_ready = 1;
      @(negedge clk);
      mem_if.mem_req_ready = 0;
      #1;
      chk("rstwait stall before", stall_m, 1);
      rst_n = 0;
      #1;
      chk("rstwait req_valid", mem_if.mem_req_valid, 0);
      chk("rstwait stall_m", stall_m, 0);
      chk("rstwait m_valid", m_valid, 0);
      @(negedge clk);
      rst_n = 1;
      mem_if.mem_resp_valid = 1; mem_if.mem_resp_rdata = 32'h55;
      @(negedge clk);
      mem_if.mem_resp_valid = 0;
      #1;
      chk("rstwait late m_valid", m_valid, 0);
      chk("rstwait late m_read_data", m_read_data, 0);
      @(negedge clk);
      #1;
      chk("rstwait late m_valid2", m_valid, 0);
      $display("reset mid-wait: done");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
